// File: rtl/reg_scan_dump_pkg.sv
// reg_scan_dump_pkg: shared widths, defaults and FSM states for the register scan/dump block
package reg_scan_dump_pkg;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_READ_LAT = 1;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, SETUP, EMIT, DONE} state_t;
endpackage

// File: rtl/reg_scan_dump_if.sv
// reg_scan_dump_if: dump-beat stream from the scanner to its consumer
interface reg_scan_dump_if;
  import reg_scan_dump_pkg::*;
  logic out_valid, out_ready, out_mismatch, out_last;
  logic [REG_ADDR_W-1:0] out_idx;
  logic [DATA_W-1:0] out_data;
  modport master(output out_valid, out_idx, out_data, out_mismatch, out_last, input out_ready);
  modport slave(input out_valid, out_idx, out_data, out_mismatch, out_last, output out_ready);
endinterface

// File: rtl/reg_scan_cmp.sv
// reg_scan_cmp: captures one read beat and flags it against its golden value
module reg_scan_cmp
  import reg_scan_dump_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_exp,
  output logic [DATA_W-1:0] o_data,
  output logic              o_mismatch,
  output logic              o_neq
);
  logic [DATA_W-1:0] r_data;
  logic r_mismatch;
  assign o_neq = i_data != i_exp;
  assign o_data = r_data;
  assign o_mismatch = r_mismatch;
  // hold the captured beat between captures so it stays stable under back-pressure
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_mismatch <= 1'b0;
    end else if (i_en) begin
      r_data <= i_data;
      r_mismatch <= o_neq;
    end
  end
endmodule

// File: rtl/reg_scan_dump.sv
// reg_scan_dump: sweeps the core register file, compares against a golden ROM and streams the beats
module reg_scan_dump
  import reg_scan_dump_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int READ_LAT = DEFAULT_READ_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [REG_ADDR_W-1:0] add_R,
  input  logic [DATA_W-1:0]     data_R,
  output logic [REG_ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0]     exp_data,
  reg_scan_dump_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic [5:0]            err_count,
  output logic                  pass
);
  localparam logic [1:0] LAT = 2'(READ_LAT);
  localparam logic [REG_ADDR_W-1:0] LAST = REG_ADDR_W'(NUM_REGS - 1);
  state_t r_state;
  logic [REG_ADDR_W-1:0] r_idx;
  logic [1:0] r_lat;
  logic [5:0] r_err;
  logic r_valid, r_last, r_busy, r_done, r_pass;
  logic w_cap, w_neq;
  assign w_cap = r_state == SETUP && r_lat == LAT;
  assign add_R = r_idx;
  assign exp_addr = r_idx;
  assign bus.out_valid = r_valid;
  assign bus.out_idx = r_idx;
  assign bus.out_last = r_last;
  assign busy = r_busy;
  assign done = r_done;
  assign err_count = r_err;
  assign pass = r_pass;
  reg_scan_cmp u_cmp (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_cap),
    .i_data    (data_R),
    .i_exp     (exp_data),
    .o_data    (bus.out_data),
    .o_mismatch(bus.out_mismatch),
    .o_neq     (w_neq)
  );
  // sweep sequencer: wait out the read latency, capture, present the beat until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_lat <= '0;
      r_err <= '0;
      r_valid <= 1'b0;
      r_last <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= SETUP;
          r_idx <= '0;
          r_lat <= '0;
          r_err <= '0;
          r_pass <= 1'b0;
          r_busy <= 1'b1;
        end
        SETUP: if (w_cap) begin
          r_state <= EMIT;
          r_lat <= '0;
          r_valid <= 1'b1;
          r_last <= r_idx == LAST;
          r_err <= r_err + 6'(w_neq);
        end else r_lat <= r_lat + 2'd1;
        EMIT: if (bus.out_ready) begin
          r_valid <= 1'b0;
          r_last <= 1'b0;
          if (r_last) begin
            r_state <= DONE;
            r_done <= 1'b1;
            r_pass <= r_err == '0;
          end else begin
            r_state <= SETUP;
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_scan_dump.sv
// tb_reg_scan_dump: scoreboard bench running READ_LAT 0/1/2 builds side by side
module tb_reg_scan_dump;
  import reg_scan_dump_pkg::*;
  typedef struct packed {logic [4:0] idx; logic [31:0] data; logic mism; logic last;} beat_t;
  localparam int N = 32;
  localparam int R_RST = 1, R_END = 2, R_TO = 3;
  logic clk = 0, rst = 1, start = 0, rdy = 0, full_rdy = 0;
  logic [31:0] regs [N], expv [N];
  logic [2:0] vld, mism, last, busy, done, pass;
  logic [2:0][4:0] oidx, addr, eaddr;
  logic [2:0][31:0] odata;
  logic [2:0][5:0] errc;
  beat_t sb [3][$];
  beat_t prev [3];
  logic [2:0] pend = '0;
  int tests = 0, fails = 0, cyc = 0, t_start = 0, nerr = 0, req = 0, rmode = 1;
  int dcnt [3] = '{0, 0, 0};
  int acc [3] = '{0, 0, 0};
  int base [3] = '{0, 0, 0};

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  for (genvar g = 0; g < 3; g++) begin : u
    reg_scan_dump_if bus ();
    logic [4:0] a, ea;
    logic [31:0] d1, d2, e1, e2;
    always @(posedge clk) begin
      d1 <= regs[a];
      d2 <= d1;
      e1 <= expv[ea];
      e2 <= e1;
    end
    assign bus.out_ready = rdy;
    reg_scan_dump #(.NUM_REGS(N), .READ_LAT(g)) dut (
      .clk(clk), .rst(rst), .start(start),
      .add_R(a), .data_R(g == 0 ? regs[a] : g == 1 ? d1 : d2),
      .exp_addr(ea), .exp_data(g == 0 ? expv[ea] : g == 1 ? e1 : e2),
      .bus(bus), .busy(busy[g]), .done(done[g]), .err_count(errc[g]), .pass(pass[g])
    );
    assign vld[g] = bus.out_valid;
    assign oidx[g] = bus.out_idx;
    assign odata[g] = bus.out_data;
    assign mism[g] = bus.out_mismatch;
    assign last[g] = bus.out_last;
    assign addr[g] = a;
    assign eaddr[g] = ea;
  end

  initial forever begin
    @(posedge clk);
    #1;
    rdy = rmode == 0 ? 1'b0 : rmode == 1 ? 1'b1 : rmode == 2 ? 1'(cyc % 3 == 2) : 1'($urandom_range(0, 3) == 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expd);
    tests++;
    if (act !== expd) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expd);
    end
  endtask

  initial forever begin
    beat_t b, e;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      if (req == R_RST) begin
        chk($sformatf("reset_state%0d", g), {vld[g], oidx[g], odata[g], mism[g], last[g], busy[g], done[g], pass[g], errc[g], addr[g], eaddr[g]}, 64'd0);
        chk($sformatf("no_done%0d", g), dcnt[g] - base[g], 0);
        sb[g].delete();
      end
      if (req == R_END) begin
        chk($sformatf("end_state%0d", g), {busy[g], vld[g], pass[g], errc[g], addr[g], eaddr[g]}, {2'b00, nerr == 0, 6'(nerr), 5'd31, 5'd31});
        chk($sformatf("one_done%0d", g), dcnt[g] - base[g], 1);
      end
      if (req == R_TO && g == 0) begin
        tests++;
        fails++;
        $display("FAIL timeout: got no done within budget, expected done on all builds");
      end
      if (rst) pend[g] = 1'b0;
      else begin
        b = {oidx[g], odata[g], mism[g], last[g]};
        if (pend[g]) chk($sformatf("hold%0d", g), {vld[g], b}, {1'b1, prev[g]});
        pend[g] = vld[g] && !rdy;
        prev[g] = b;
        if (vld[g] && rdy) begin
          acc[g]++;
          if (sb[g].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_beat%0d: got idx %0d, expected no beat", g, oidx[g]);
          end else begin
            e = sb[g].pop_front();
            chk($sformatf("beat%0d", g), b, e);
          end
        end
        if (done[g]) begin
          dcnt[g]++;
          chk($sformatf("done_err%0d", g), {errc[g], pass[g]}, {6'(nerr), nerr == 0});
          chk($sformatf("done_left%0d", g), sb[g].size(), 0);
          if (full_rdy) chk($sformatf("done_cyc%0d", g), cyc - t_start, 1 + N * (g + 2));
        end
      end
    end
  end

  task automatic request(input int k);
    req = k;
    @(negedge clk);
    #1 req = 0;
  endtask

  task automatic load(input int mode);
    for (int i = 0; i < N; i++) begin
      regs[i] = mode == 0 ? 32'(i * 3) : $urandom;
      expv[i] = (mode == 2 && $urandom_range(0, 3) == 0) ? $urandom : regs[i];
    end
  endtask

  task automatic prep();
    nerr = 0;
    for (int i = 0; i < N; i++) begin
      if (regs[i] != expv[i]) nerr++;
      for (int g = 0; g < 3; g++) sb[g].push_back({5'(i), regs[i], regs[i] != expv[i], i == N - 1});
    end
    for (int g = 0; g < 3; g++) base[g] = dcnt[g];
    @(posedge clk);
    #1 start = 1;
    t_start = cyc;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic sweep(input logic full, input int extra);
    full_rdy = full;
    prep();
    for (int k = 0; k < extra; k++) begin
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #1 start = 1;
      @(posedge clk);
      #1 start = 0;
    end
    for (int t = 0; t < 6000; t++) begin
      @(posedge clk);
      if (dcnt[0] > base[0] && dcnt[1] > base[1] && dcnt[2] > base[2]) break;
    end
    #1;
    if (!(dcnt[0] > base[0] && dcnt[1] > base[1] && dcnt[2] > base[2])) request(R_TO);
    repeat (3) @(posedge clk);
    #1 request(R_END);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    request(R_RST);
    rmode = 1;
    load(0);
    sweep(1, 0);
    load(1);
    regs[5] = 32'hDEADBEEF;
    expv[5] = 32'h0;
    regs[17] ^= 32'h1;
    sweep(1, 0);
    rmode = 2;
    load(2);
    sweep(0, 0);
    rmode = 3;
    load(2);
    sweep(0, 0);
    rmode = 1;
    full_rdy = 0;
    load(2);
    prep();
    for (int t = 0; t < 2000 && acc[1] < base[1] + 10; t++) begin
      @(posedge clk);
      #1 base[1] = base[1];
    end
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    request(R_RST);
    rmode = 3;
    load(2);
    sweep(0, 3);
    for (int g = 0; g < 3; g++) base[g] = dcnt[g];
    @(posedge clk);
    #1 begin rst = 1; start = 1; end
    @(posedge clk);
    #1 begin rst = 0; start = 0; end
    repeat (3) @(posedge clk);
    #1 request(R_RST);
    rmode = 1;
    load(1);
    sweep(1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
